// File: rtl/chip_6502_core.sv
// chip_6502_core: cycle-stepped 6502-subset CPU with a 6502-style external bus.
// Runs the reset-vector fetch and a small instruction subset (loads, ADC#,
// register inc/dec/transfer, CLC/SEC, JMP abs, STA abs); unknown opcodes act
// as 2-cycle NOPs. One bus cycle completes per posedge clk with phi=1.
//
// Ports
//   clk   in   system clock, all state updates on posedge
//   res   in   synchronous active-low reset (overrides phi, rdy, so)
//   phi   in   bus-cycle enable
//   so    in   set-overflow, falling edge (seen on enabled edges) sets P.V
//   rdy   in   ready, low stalls read cycles
//   nmi   in   reserved, ignored
//   irq   in   reserved, ignored
//   dbi   in   read data for the address on ab
//   dbo   out  write data, valid when rw=0 (holds last value otherwise)
//   rw    out  1=read, 0=write
//   sync  out  high during an opcode-fetch cycle
//   ab    out  address bus
module chip_6502_core #(
    parameter logic [7:0] RESET_SP = 8'hFD,
    parameter logic [7:0] RESET_P  = 8'h34
) (
    input  logic        clk,
    input  logic        res,
    input  logic        phi,
    input  logic        so,
    input  logic        rdy,
    input  logic        nmi,
    input  logic        irq,
    input  logic [7:0]  dbi,
    output logic [7:0]  dbo,
    output logic        rw,
    output logic        sync,
    output logic [15:0] ab
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    // Status register bit positions
    localparam int unsigned P_C = 0;
    localparam int unsigned P_Z = 1;
    localparam int unsigned P_V = 6;
    localparam int unsigned P_N = 7;

    localparam logic [DW-1:0] OP_LDA = 8'hA9;
    localparam logic [DW-1:0] OP_LDX = 8'hA2;
    localparam logic [DW-1:0] OP_LDY = 8'hA0;
    localparam logic [DW-1:0] OP_ADC = 8'h69;
    localparam logic [DW-1:0] OP_INX = 8'hE8;
    localparam logic [DW-1:0] OP_INY = 8'hC8;
    localparam logic [DW-1:0] OP_DEX = 8'hCA;
    localparam logic [DW-1:0] OP_DEY = 8'h88;
    localparam logic [DW-1:0] OP_TAX = 8'hAA;
    localparam logic [DW-1:0] OP_TXA = 8'h8A;
    localparam logic [DW-1:0] OP_CLC = 8'h18;
    localparam logic [DW-1:0] OP_SEC = 8'h38;
    localparam logic [DW-1:0] OP_JMP = 8'h4C;
    localparam logic [DW-1:0] OP_STA = 8'h8D;

    // Each state names the bus cycle currently presented on ab
    typedef enum logic [2:0] {
        ST_VEC_LO,
        ST_VEC_HI,
        ST_FETCH,
        ST_EXEC,
        ST_ABS_LO,
        ST_ABS_HI,
        ST_WRITE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt;
    logic [AW-1:0] r_ab, w_ab_nxt;
    logic          r_rw, w_rw_nxt;
    logic          r_sync, w_sync_nxt;
    logic [DW-1:0] r_dbo, w_dbo_nxt;
    logic [DW-1:0] r_a, w_a_nxt;
    logic [DW-1:0] r_x, w_x_nxt;
    logic [DW-1:0] r_y, w_y_nxt;
    logic [DW-1:0] r_p, w_p_nxt;
    logic [DW-1:0] r_s;
    logic [DW-1:0] r_ir, w_ir_nxt;
    logic [DW-1:0] r_lo, w_lo_nxt;
    logic          r_so_prev;

    logic          w_go;
    logic          w_imm;
    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_abs;
    logic [DW:0]   w_sum;
    logic          w_adc_v;
    logic          w_nz_en;
    logic [DW-1:0] w_nz_val;
    logic          w_unused;

    assign dbo  = r_dbo;
    assign rw   = r_rw;
    assign sync = r_sync;
    assign ab   = r_ab;

    // Reserved inputs and the untouched stack pointer have no consumers yet
    assign w_unused = ^{nmi, irq, r_s};

    // Write cycles always complete; read cycles wait for rdy
    assign w_go     = rdy | ~r_rw;
    assign w_imm    = (r_ir == OP_LDA) || (r_ir == OP_LDX) ||
                      (r_ir == OP_LDY) || (r_ir == OP_ADC);
    assign w_pc_inc = r_pc + AW'(1);
    assign w_abs    = {dbi, r_lo};
    assign w_sum    = {1'b0, r_a} + {1'b0, dbi} + {{DW{1'b0}}, r_p[P_C]};
    // Overflow when both addends share a sign that the result does not
    assign w_adc_v  = (r_a[7] == dbi[7]) && (w_sum[7] != r_a[7]);

    // State register
    always_ff @(posedge clk) begin
        if (!res) begin
            r_state <= ST_VEC_LO;
        end else if (phi) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, bus and register updates for the cycle ending on this edge
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ab_nxt    = r_ab;
        w_rw_nxt    = r_rw;
        w_sync_nxt  = r_sync;
        w_dbo_nxt   = r_dbo;
        w_a_nxt     = r_a;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_p_nxt     = r_p;
        w_ir_nxt    = r_ir;
        w_lo_nxt    = r_lo;
        w_nz_en     = 1'b0;
        w_nz_val    = '0;

        if (w_go) begin
            case (r_state)
                ST_VEC_LO: begin
                    w_pc_nxt    = {r_pc[15:8], dbi};
                    w_ab_nxt    = 16'hFFFD;
                    w_state_nxt = ST_VEC_HI;
                end
                ST_VEC_HI: begin
                    w_pc_nxt    = {dbi, r_pc[7:0]};
                    w_ab_nxt    = {dbi, r_pc[7:0]};
                    w_sync_nxt  = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    // Next cycle reads the new PC: operand byte or dummy read
                    w_ir_nxt    = dbi;
                    w_pc_nxt    = w_pc_inc;
                    w_ab_nxt    = w_pc_inc;
                    w_sync_nxt  = 1'b0;
                    w_state_nxt = ((dbi == OP_JMP) || (dbi == OP_STA)) ?
                                  ST_ABS_LO : ST_EXEC;
                end
                ST_EXEC: begin
                    case (r_ir)
                        OP_LDA: begin
                            w_a_nxt  = dbi;
                            w_nz_en  = 1'b1;
                            w_nz_val = dbi;
                        end
                        OP_LDX: begin
                            w_x_nxt  = dbi;
                            w_nz_en  = 1'b1;
                            w_nz_val = dbi;
                        end
                        OP_LDY: begin
                            w_y_nxt  = dbi;
                            w_nz_en  = 1'b1;
                            w_nz_val = dbi;
                        end
                        OP_ADC: begin
                            w_a_nxt      = w_sum[DW-1:0];
                            w_p_nxt[P_C] = w_sum[DW];
                            w_p_nxt[P_V] = w_adc_v;
                            w_nz_en      = 1'b1;
                            w_nz_val     = w_sum[DW-1:0];
                        end
                        OP_INX: begin
                            w_x_nxt  = r_x + DW'(1);
                            w_nz_en  = 1'b1;
                            w_nz_val = w_x_nxt;
                        end
                        OP_INY: begin
                            w_y_nxt  = r_y + DW'(1);
                            w_nz_en  = 1'b1;
                            w_nz_val = w_y_nxt;
                        end
                        OP_DEX: begin
                            w_x_nxt  = r_x - DW'(1);
                            w_nz_en  = 1'b1;
                            w_nz_val = w_x_nxt;
                        end
                        OP_DEY: begin
                            w_y_nxt  = r_y - DW'(1);
                            w_nz_en  = 1'b1;
                            w_nz_val = w_y_nxt;
                        end
                        OP_TAX: begin
                            w_x_nxt  = r_a;
                            w_nz_en  = 1'b1;
                            w_nz_val = r_a;
                        end
                        OP_TXA: begin
                            w_a_nxt  = r_x;
                            w_nz_en  = 1'b1;
                            w_nz_val = r_x;
                        end
                        OP_CLC: w_p_nxt[P_C] = 1'b0;
                        OP_SEC: w_p_nxt[P_C] = 1'b1;
                        default: ;
                    endcase
                    // Immediate ops consumed the byte at PC; 1-byte ops refetch it
                    if (w_imm) begin
                        w_pc_nxt = w_pc_inc;
                        w_ab_nxt = w_pc_inc;
                    end else begin
                        w_ab_nxt = r_pc;
                    end
                    w_sync_nxt  = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
                ST_ABS_LO: begin
                    w_lo_nxt    = dbi;
                    w_pc_nxt    = w_pc_inc;
                    w_ab_nxt    = w_pc_inc;
                    w_state_nxt = ST_ABS_HI;
                end
                ST_ABS_HI: begin
                    if (r_ir == OP_JMP) begin
                        w_pc_nxt    = w_abs;
                        w_ab_nxt    = w_abs;
                        w_sync_nxt  = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_pc_nxt    = w_pc_inc;
                        w_ab_nxt    = w_abs;
                        w_rw_nxt    = 1'b0;
                        w_dbo_nxt   = r_a;
                        w_state_nxt = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    w_rw_nxt    = 1'b1;
                    w_ab_nxt    = r_pc;
                    w_sync_nxt  = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
                default: begin
                    w_state_nxt = ST_VEC_LO;
                end
            endcase

            if (w_nz_en) begin
                w_p_nxt[P_N] = w_nz_val[7];
                w_p_nxt[P_Z] = (w_nz_val == '0);
            end
        end

        // SO edge detect runs on every enabled edge, independent of rdy
        if (r_so_prev && !so) begin
            w_p_nxt[P_V] = 1'b1;
        end
    end

    // Datapath and bus registers
    always_ff @(posedge clk) begin
        if (!res) begin
            r_pc      <= '0;
            r_ab      <= 16'hFFFC;
            r_rw      <= 1'b1;
            r_sync    <= 1'b0;
            r_dbo     <= '0;
            r_a       <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_s       <= RESET_SP;
            r_p       <= RESET_P;
            r_ir      <= '0;
            r_lo      <= '0;
            r_so_prev <= 1'b0;
        end else if (phi) begin
            r_pc      <= w_pc_nxt;
            r_ab      <= w_ab_nxt;
            r_rw      <= w_rw_nxt;
            r_sync    <= w_sync_nxt;
            r_dbo     <= w_dbo_nxt;
            r_a       <= w_a_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_p       <= w_p_nxt;
            r_ir      <= w_ir_nxt;
            r_lo      <= w_lo_nxt;
            r_so_prev <= so;
        end
    end

endmodule

// File: tb/tb_chip_6502_core.sv
// Testbench for chip_6502_core: directed programs plus randomized memory images,
// compared cycle by cycle against an instruction-level reference model.
module tb_chip_6502_core;

    logic        clk = 1'b0;
    logic        res, phi, so, rdy, nmi, irq;
    logic [7:0]  dbi, dbo;
    logic        rw, sync;
    logic [15:0] ab;

    chip_6502_core dut (
        .clk  (clk),
        .res  (res),
        .phi  (phi),
        .so   (so),
        .rdy  (rdy),
        .nmi  (nmi),
        .irq  (irq),
        .dbi  (dbi),
        .dbo  (dbo),
        .rw   (rw),
        .sync (sync),
        .ab   (ab)
    );

    always #5 clk = ~clk;

    // One expected bus cycle; register snapshot is meaningful on fetch cycles
    typedef struct {
        logic [15:0] ab;
        logic        rw;
        logic        sync;
        logic [7:0]  dbo;
        logic [7:0]  a, x, y, p;
    } cyc_t;

    logic [7:0]  mem [0:65535];
    cyc_t        q[$];
    cyc_t        cur;
    logic [15:0] m_pc;
    logic [7:0]  m_a, m_x, m_y;
    logic        m_n, m_v, m_z, m_c;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_p();
        return {m_n, m_v, 1'b1, 1'b1, 1'b0, 1'b1, m_z, m_c};
    endfunction

    task automatic push(input logic [15:0] a, input logic r, input logic s, input logic [7:0] d);
        cyc_t e;
        e.ab = a; e.rw = r; e.sync = s; e.dbo = d;
        e.a = m_a; e.x = m_x; e.y = m_y; e.p = m_p();
        q.push_back(e);
    endtask

    task automatic setnz(input logic [7:0] v);
        m_n = v[7];
        m_z = (v == 8'h00);
    endtask

    // Instruction-level model: emits all bus cycles of the next instruction
    task automatic model_step();
        logic [7:0]  op, m, lo;
        logic [15:0] adr;
        int          sr, ur;
        push(m_pc, 1'b1, 1'b1, 8'h00);
        op   = mem[m_pc];
        m_pc = m_pc + 16'd1;
        case (op)
            8'hA9, 8'hA2, 8'hA0, 8'h69: begin
                push(m_pc, 1'b1, 1'b0, 8'h00);
                m    = mem[m_pc];
                m_pc = m_pc + 16'd1;
                if (op == 8'hA9) begin
                    m_a = m; setnz(m_a);
                end else if (op == 8'hA2) begin
                    m_x = m; setnz(m_x);
                end else if (op == 8'hA0) begin
                    m_y = m; setnz(m_y);
                end else begin
                    sr  = int'($signed(m_a)) + int'($signed(m)) + int'(m_c);
                    ur  = int'(m_a) + int'(m) + int'(m_c);
                    m_v = (sr > 127) || (sr < -128);
                    m_c = (ur > 255);
                    m_a = 8'(ur);
                    setnz(m_a);
                end
            end
            8'h4C: begin
                push(m_pc, 1'b1, 1'b0, 8'h00);
                lo   = mem[m_pc];
                m_pc = m_pc + 16'd1;
                push(m_pc, 1'b1, 1'b0, 8'h00);
                m_pc = {mem[m_pc], lo};
            end
            8'h8D: begin
                push(m_pc, 1'b1, 1'b0, 8'h00);
                lo   = mem[m_pc];
                m_pc = m_pc + 16'd1;
                push(m_pc, 1'b1, 1'b0, 8'h00);
                adr  = {mem[m_pc], lo};
                m_pc = m_pc + 16'd1;
                push(adr, 1'b0, 1'b0, m_a);
            end
            default: begin
                push(m_pc, 1'b1, 1'b0, 8'h00);
                case (op)
                    8'hE8: begin m_x = m_x + 8'd1; setnz(m_x); end
                    8'hC8: begin m_y = m_y + 8'd1; setnz(m_y); end
                    8'hCA: begin m_x = m_x - 8'd1; setnz(m_x); end
                    8'h88: begin m_y = m_y - 8'd1; setnz(m_y); end
                    8'hAA: begin m_x = m_a; setnz(m_x); end
                    8'h8A: begin m_a = m_x; setnz(m_a); end
                    8'h18: m_c = 1'b0;
                    8'h38: m_c = 1'b1;
                    default: ;
                endcase
            end
        endcase
    endtask

    // One clock edge; memory answers the presented address and absorbs writes
    task automatic tick(input logic p, input logic r);
        logic        wr;
        logic [15:0] wa;
        logic [7:0]  wd;
        phi = p;
        rdy = r;
        dbi = mem[ab];
        wr  = p && res && (rw == 1'b0);
        wa  = ab;
        wd  = dbo;
        @(posedge clk);
        if (wr) mem[wa] = wd;
        #1;
    endtask

    // One edge with bus check against the model's expected cycle
    task automatic run_cycle(input logic p, input logic r);
        logic adv;
        adv = p && (r || !cur.rw);
        tick(p, r);
        if (adv) begin
            if (q.size() == 0) model_step();
            cur = q.pop_front();
        end
        chk("ab", ab, cur.ab);
        chk("rw", 16'(rw), 16'(cur.rw));
        chk("sync", 16'(sync), 16'(cur.sync));
        if (!cur.rw) chk("dbo", 16'(dbo), 16'(cur.dbo));
        if (cur.sync) begin
            chk("reg_a", 16'(dut.r_a), 16'(cur.a));
            chk("reg_x", 16'(dut.r_x), 16'(cur.x));
            chk("reg_y", 16'(dut.r_y), 16'(cur.y));
            chk("reg_p", 16'(dut.r_p), 16'(cur.p));
        end
    endtask

    task automatic do_reset(input logic [15:0] vec);
        mem[16'hFFFC] = vec[7:0];
        mem[16'hFFFD] = vec[15:8];
        res = 1'b0;
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        chk("rst_ab", ab, 16'hFFFC);
        chk("rst_rw", 16'(rw), 16'h0001);
        chk("rst_sync", 16'(sync), 16'h0000);
        chk("rst_dbo", 16'(dbo), 16'h0000);
        chk("rst_a", 16'(dut.r_a), 16'h0000);
        chk("rst_x", 16'(dut.r_x), 16'h0000);
        chk("rst_y", 16'(dut.r_y), 16'h0000);
        chk("rst_s", 16'(dut.r_s), 16'h00FD);
        chk("rst_p", 16'(dut.r_p), 16'h0034);
        res  = 1'b1;
        m_a  = 8'h00; m_x = 8'h00; m_y = 8'h00;
        m_n  = 1'b0;  m_v = 1'b0;  m_z = 1'b0; m_c = 1'b0;
        m_pc = vec;
        q.delete();
        cur.ab = 16'hFFFC; cur.rw = 1'b1; cur.sync = 1'b0; cur.dbo = 8'h00;
        cur.a = 8'h00; cur.x = 8'h00; cur.y = 8'h00; cur.p = 8'h34;
        push(16'hFFFD, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 65536; i++) mem[i] = v;
    endtask

    function automatic logic [7:0] rnd_byte();
        case ($urandom_range(0, 19))
            0:  return 8'hEA;
            1:  return 8'hA9;
            2:  return 8'hA2;
            3:  return 8'hA0;
            4:  return 8'h69;
            5:  return 8'hE8;
            6:  return 8'hC8;
            7:  return 8'hCA;
            8:  return 8'h88;
            9:  return 8'hAA;
            10: return 8'h8A;
            11: return 8'h18;
            12: return 8'h38;
            13: return 8'h8D;
            14: return 8'h4C;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic load(input logic [15:0] base, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        mem[base]         = b0;
        mem[base + 16'd1] = b1;
        mem[base + 16'd2] = b2;
        mem[base + 16'd3] = b3;
        mem[base + 16'd4] = b4;
    endtask

    logic [15:0] sled_ab [0:5];
    logic        sled_sy [0:5];

    initial begin
        res = 1'b0; phi = 1'b0; so = 1'b1; rdy = 1'b1; nmi = 1'b0; irq = 1'b0; dbi = 8'h00;
        sled_ab[0] = 16'hFFFD; sled_ab[1] = 16'hEAEA; sled_ab[2] = 16'hEAEB;
        sled_ab[3] = 16'hEAEB; sled_ab[4] = 16'hEAEC; sled_ab[5] = 16'hEAEC;
        sled_sy[0] = 1'b0; sled_sy[1] = 1'b1; sled_sy[2] = 1'b0;
        sled_sy[3] = 1'b1; sled_sy[4] = 1'b0; sled_sy[5] = 1'b1;

        // NOP sled with literal address sequence, then stalls and phi=0 edges
        fill(8'hEA);
        do_reset(16'hEAEA);
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b1, 1'b1);
            chk("sled_ab", ab, sled_ab[i]);
            chk("sled_sync", 16'(sync), 16'(sled_sy[i]));
        end
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
        chk("stall_ab", ab, 16'hEAEC);
        for (int i = 0; i < 2; i++) run_cycle(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1);
        chk("resume_ab", ab, 16'hEAEE);

        // Falling edge of so sets V
        so = 1'b1;
        tick(1'b1, 1'b1);
        so = 1'b0;
        tick(1'b1, 1'b1);
        chk("so_v", 16'(dut.r_p[6]), 16'h0001);
        so = 1'b1;

        // Store: LDA #42; STA $0200
        fill(8'hEA);
        load(16'h8000, 8'hA9, 8'h42, 8'h8D, 8'h00, 8'h02);
        mem[16'h0200] = 8'h00;
        do_reset(16'h8000);
        for (int i = 0; i < 7; i++) run_cycle(1'b1, 1'b1);
        chk("sta_ab", ab, 16'h0200);
        chk("sta_rw", 16'(rw), 16'h0000);
        chk("sta_dbo", 16'(dbo), 16'h0042);
        run_cycle(1'b1, 1'b1);
        chk("sta_next_ab", ab, 16'h8005);
        chk("sta_next_sync", 16'(sync), 16'h0001);
        chk("sta_mem", 16'(mem[16'h0200]), 16'h0042);

        // JMP $1234
        fill(8'hEA);
        load(16'h8000, 8'h4C, 8'h34, 8'h12, 8'hEA, 8'hEA);
        do_reset(16'h8000);
        for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b1);
        chk("jmp_ab", ab, 16'h1234);
        chk("jmp_sync", 16'(sync), 16'h0001);

        // LDX #FF; INX; LDA #7F; CLC; ADC #01
        fill(8'hEA);
        load(16'h8000, 8'hA2, 8'hFF, 8'hE8, 8'hA9, 8'h7F);
        load(16'h8005, 8'h18, 8'h69, 8'h01, 8'hEA, 8'hEA);
        do_reset(16'h8000);
        for (int i = 0; i < 7; i++) run_cycle(1'b1, 1'b1);
        chk("inx_x", 16'(dut.r_x), 16'h0000);
        chk("inx_z", 16'(dut.r_p[1]), 16'h0001);
        chk("inx_n", 16'(dut.r_p[7]), 16'h0000);
        for (int i = 0; i < 7; i++) run_cycle(1'b1, 1'b1);
        chk("adc_a", 16'(dut.r_a), 16'h0080);
        chk("adc_v", 16'(dut.r_p[6]), 16'h0001);
        chk("adc_n", 16'(dut.r_p[7]), 16'h0001);
        chk("adc_c", 16'(dut.r_p[0]), 16'h0000);

        // Reset during STA operand fetch aborts the write
        fill(8'hEA);
        load(16'h8000, 8'h8D, 8'h00, 8'h02, 8'hEA, 8'hEA);
        mem[16'h0200] = 8'h55;
        do_reset(16'h8000);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1);
        chk("abort_pre_ab", ab, 16'h8001);
        res = 1'b0;
        tick(1'b1, 1'b1);
        chk("abort_ab", ab, 16'hFFFC);
        chk("abort_rw", 16'(rw), 16'h0001);
        chk("abort_sync", 16'(sync), 16'h0000);
        tick(1'b1, 1'b1);
        chk("abort_rw2", 16'(rw), 16'h0001);
        chk("abort_mem", 16'(mem[16'h0200]), 16'h0055);

        // Randomized memory images with random phi/rdy
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 65536; i++) mem[i] = rnd_byte();
            do_reset(16'($urandom));
            for (int i = 0; i < 2500; i++) begin
                run_cycle(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 8));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
